// File: rtl/GLOBAL_PARAM.sv
// rtl/GLOBAL_PARAM.sv - shared DDR interface widths and arbiter state encoding
package GLOBAL_PARAM;

   localparam int DDR_W      = 64;
   localparam int DDR_ADDR_W = 32;
   localparam int BURST_W    = 4;

   // Shared with the read-side arbiter so both walk the same burst phases.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority encoder
module rr_pick #(
   parameter int REQ_NUM = 2
)(
   input  logic [REQ_NUM-1:0]         req,
   input  logic [$clog2(REQ_NUM)-1:0] ptr,
   output logic [$clog2(REQ_NUM)-1:0] sel,
   output logic                       any
);

   localparam int GW = $clog2(REQ_NUM);

   int idx;

   always_comb begin
      sel = '0;
      any = 1'b0;
      idx = 0;
      // Scan from farthest to nearest so the candidate closest to ptr is written last.
      for (int i = REQ_NUM - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % REQ_NUM;
         if (req[GW'(idx)]) begin
            sel = GW'(idx);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ddr_wr_arb.sv
// rtl/ddr_wr_arb.sv - burst-granular round-robin arbiter for one shared DDR write port
module ddr_wr_arb #(
   parameter int REQ_NUM    = 2,
   parameter int DDR_W      = GLOBAL_PARAM::DDR_W,
   parameter int DDR_ADDR_W = GLOBAL_PARAM::DDR_ADDR_W,
   parameter int BURST_W    = GLOBAL_PARAM::BURST_W
)(
   input  logic                            clk,
   input  logic                            rst,
   input  logic [REQ_NUM*DDR_ADDR_W-1:0]   req_addr,
   input  logic [REQ_NUM*BURST_W-1:0]      req_size,
   input  logic [REQ_NUM-1:0]              req_addr_valid,
   output logic [REQ_NUM-1:0]              req_addr_ready,
   input  logic [REQ_NUM*DDR_W-1:0]        req_data,
   input  logic [REQ_NUM-1:0]              req_valid,
   output logic [REQ_NUM-1:0]              req_ready,
   output logic [DDR_ADDR_W-1:0]           ddr_addr,
   output logic [BURST_W-1:0]              ddr_size,
   output logic                            ddr_addr_valid,
   input  logic                            ddr_addr_ready,
   output logic [DDR_W-1:0]                ddr_data,
   output logic                            ddr_valid,
   input  logic                            ddr_ready,
   output logic [$clog2(REQ_NUM)-1:0]      grant,
   output logic                            busy
);

   import GLOBAL_PARAM::*;

   localparam int GW = $clog2(REQ_NUM);

   arb_state_t          state, state_nxt;
   logic [GW-1:0]       rr_ptr, rr_ptr_nxt, grant_nxt, pick_sel;
   logic                pick_any;
   logic [BURST_W-1:0]  cnt, cnt_nxt;

   logic [DDR_ADDR_W-1:0] addr_arr [REQ_NUM];
   logic [BURST_W-1:0]    size_arr [REQ_NUM];
   logic [DDR_W-1:0]      data_arr [REQ_NUM];

   for (genvar g = 0; g < REQ_NUM; g++) begin : g_unpack
      assign addr_arr[g] = req_addr[g*DDR_ADDR_W +: DDR_ADDR_W];
      assign size_arr[g] = req_size[g*BURST_W +: BURST_W];
      assign data_arr[g] = req_data[g*DDR_W +: DDR_W];
   end

   rr_pick #(
      .REQ_NUM (REQ_NUM)
   ) u_rr_pick (
      .req (req_addr_valid),
      .ptr (rr_ptr),
      .sel (pick_sel),
      .any (pick_any)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         rr_ptr <= '0;
         grant  <= '0;
         cnt    <= '0;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_ptr_nxt;
         grant  <= grant_nxt;
         cnt    <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      rr_ptr_nxt     = rr_ptr;
      grant_nxt      = grant;
      cnt_nxt        = cnt;
      ddr_addr       = '0;
      ddr_size       = '0;
      ddr_addr_valid = 1'b0;
      ddr_data       = '0;
      ddr_valid      = 1'b0;
      req_addr_ready = '0;
      req_ready      = '0;

      case (state)
         IDLE: begin
            if (pick_any) begin
               grant_nxt = pick_sel;
               state_nxt = ADDR;
            end
         end
         ADDR: begin
            ddr_addr              = addr_arr[grant];
            ddr_size              = size_arr[grant];
            ddr_addr_valid        = req_addr_valid[grant];
            req_addr_ready[grant] = ddr_addr_ready;
            if (req_addr_valid[grant] && ddr_addr_ready) begin
               cnt_nxt   = size_arr[grant];
               state_nxt = DATA;
            end
         end
         DATA: begin
            ddr_data         = data_arr[grant];
            ddr_valid        = req_valid[grant];
            req_ready[grant] = ddr_ready;
            if (req_valid[grant] && ddr_ready) begin
               // cnt holds beats remaining after this one, so zero marks the last beat.
               if (cnt == '0) begin
                  state_nxt  = IDLE;
                  rr_ptr_nxt = (int'(grant) == REQ_NUM - 1) ? '0 : grant + 1'b1;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ddr_wr_arb.sv
// tb/tb_ddr_wr_arb.sv - randomized self-checking bench for ddr_wr_arb
module tb_ddr_wr_arb;

   import GLOBAL_PARAM::*;

   localparam int N  = 2;
   localparam int AW = DDR_ADDR_W;
   localparam int DW = DDR_W;
   localparam int BW = BURST_W;
   localparam int GW = $clog2(N);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N*AW-1:0]   req_addr;
   logic [N*BW-1:0]   req_size;
   logic [N-1:0]      req_addr_valid, req_addr_ready;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_valid, req_ready;
   logic [AW-1:0]     ddr_addr;
   logic [BW-1:0]     ddr_size;
   logic              ddr_addr_valid, ddr_addr_ready;
   logic [DW-1:0]     ddr_data;
   logic              ddr_valid, ddr_ready;
   logic [GW-1:0]     grant;
   logic              busy;

   always #5 clk = ~clk;

   ddr_wr_arb #(.REQ_NUM(N)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_addr       (req_addr),
      .req_size       (req_size),
      .req_addr_valid (req_addr_valid),
      .req_addr_ready (req_addr_ready),
      .req_data       (req_data),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .ddr_addr       (ddr_addr),
      .ddr_size       (ddr_size),
      .ddr_addr_valid (ddr_addr_valid),
      .ddr_addr_ready (ddr_addr_ready),
      .ddr_data       (ddr_data),
      .ddr_valid      (ddr_valid),
      .ddr_ready      (ddr_ready),
      .grant          (grant),
      .busy           (busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Requester-side burst queues and progress.
   logic [AW-1:0] q_addr [N][$];
   int            q_size [N][$];
   int            q_tag  [N][$];
   bit            addr_sent [N];
   int            beat [N];
   int            gap  [N];
   int            tag_ctr = 0;

   // Transaction-level reference: who owns the port, and the grant history.
   bit  m_free, m_addr_done;
   int  m_ptr, m_cur, m_grant;
   int  hist [$];
   int  n_addr_hs, n_data_hs, exp_beats;

   int  p_ardy, p_rdy, p_val, p_early, max_gap;
   bit  stall_pat;
   logic [3:0] stall_seq = 4'b1001;
   int  cyc = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [DW-1:0] exp_data(input int r, input int tag, input int b);
      return DW'({8'(r), 24'(tag), 32'(b)});
   endfunction

   function automatic logic [N-1:0] onehot(input int r, input logic b);
      logic [N-1:0] v;
      v = '0;
      v[GW'(r)] = b;
      return v;
   endfunction

   function automatic int rr_expect(input logic [N-1:0] pend, input int ptr);
      for (int i = 0; i < N; i++)
         if (pend[GW'((ptr + i) % N)]) return (ptr + i) % N;
      return -1;
   endfunction

   function automatic bit pending_any();
      for (int r = 0; r < N; r++)
         if (q_size[r].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic push(input int r, input logic [AW-1:0] a, input int s);
      q_addr[r].push_back(a);
      q_size[r].push_back(s);
      q_tag[r].push_back(tag_ctr);
      tag_ctr++;
      exp_beats += s + 1;
   endtask

   task automatic check_zero();
      chk("rst_handshakes", 64'({ddr_addr_valid, ddr_valid, req_addr_ready, req_ready}), 64'(0));
      chk("rst_busy_grant", 64'({busy, grant}), 64'(0));
      chk("rst_addr", 64'(ddr_addr), 64'(0));
      chk("rst_size", 64'(ddr_size), 64'(0));
      chk("rst_data", 64'(ddr_data), 64'(0));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      check_zero();
      for (int r = 0; r < N; r++) begin
         q_addr[r].delete(); q_size[r].delete(); q_tag[r].delete();
         addr_sent[r] = 1'b0; beat[r] = 0; gap[r] = 0;
      end
      req_addr = '0; req_size = '0; req_addr_valid = '0;
      req_data = '0; req_valid = '0; ddr_addr_ready = 1'b0; ddr_ready = 1'b0;
      m_free = 1'b1; m_addr_done = 1'b0; m_ptr = 0; m_cur = 0; m_grant = 0;
      hist.delete();
      n_addr_hs = 0; n_data_hs = 0; exp_beats = 0;
      p_ardy = 100; p_rdy = 100; p_val = 100; p_early = 0; max_gap = 0; stall_pat = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("post_rst_busy_grant", 64'({busy, grant}), 64'(0));
   endtask

   task automatic cycle();
      logic [N-1:0] s_av, s_ar, s_v, s_r;
      bit           was_free;
      ddr_addr_ready = ($urandom_range(99) < p_ardy);
      ddr_ready = stall_pat ? stall_seq[cyc % 4] : ($urandom_range(99) < p_rdy);
      for (int r = 0; r < N; r++) begin
         if (q_size[r].size() > 0 && gap[r] == 0) begin
            req_addr[r*AW +: AW]  = q_addr[r][0];
            req_size[r*BW +: BW]  = BW'(q_size[r][0]);
            req_addr_valid[r]     = !addr_sent[r];
            req_valid[r]          = addr_sent[r] ? ($urandom_range(99) < p_val)
                                                 : ($urandom_range(99) < p_early);
            req_data[r*DW +: DW]  = exp_data(r, q_tag[r][0], beat[r]);
         end else begin
            req_addr[r*AW +: AW]  = '0;
            req_size[r*BW +: BW]  = '0;
            req_addr_valid[r]     = 1'b0;
            req_valid[r]          = 1'b0;
            req_data[r*DW +: DW]  = '0;
         end
      end
      #1;
      chk("busy", 64'(busy), 64'(!m_free));
      chk("grant", 64'(grant), 64'(m_grant));
      if (m_free) begin
         chk("idle_out", 64'({ddr_addr_valid, ddr_valid, req_addr_ready, req_ready}), 64'(0));
      end else if (!m_addr_done) begin
         chk("addr_phase_valid", 64'({ddr_addr_valid, ddr_valid}), 64'({req_addr_valid[GW'(m_cur)], 1'b0}));
         chk("ddr_addr", 64'(ddr_addr), 64'(q_addr[m_cur][0]));
         chk("ddr_size", 64'(ddr_size), 64'(q_size[m_cur][0]));
         chk("req_addr_ready", 64'(req_addr_ready), 64'(onehot(m_cur, ddr_addr_ready)));
         chk("req_ready_in_addr", 64'(req_ready), 64'(0));
      end else begin
         chk("data_phase_valid", 64'({ddr_addr_valid, ddr_valid}), 64'({1'b0, req_valid[GW'(m_cur)]}));
         if (req_valid[GW'(m_cur)])
            chk("ddr_data", 64'(ddr_data), 64'(exp_data(m_cur, q_tag[m_cur][0], beat[m_cur])));
         chk("req_ready", 64'(req_ready), 64'(onehot(m_cur, ddr_ready)));
         chk("req_addr_ready_in_data", 64'(req_addr_ready), 64'(0));
      end
      s_av = req_addr_valid; s_ar = req_addr_ready; s_v = req_valid; s_r = req_ready;
      was_free = m_free;
      @(posedge clk);
      #1;
      cyc++;
      if (was_free && (s_av != '0)) begin
         m_cur = rr_expect(s_av, m_ptr);
         m_grant = m_cur;
         m_free = 1'b0;
         m_addr_done = 1'b0;
         hist.push_back(m_cur);
      end
      for (int r = 0; r < N; r++) begin
         if (s_av[r] && s_ar[r]) begin
            addr_sent[r] = 1'b1;
            n_addr_hs++;
            if (!was_free && r == m_cur) m_addr_done = 1'b1;
         end else if (s_v[r] && s_r[r]) begin
            n_data_hs++;
            beat[r]++;
            if (beat[r] > q_size[r][0]) begin
               void'(q_addr[r].pop_front()); void'(q_size[r].pop_front()); void'(q_tag[r].pop_front());
               addr_sent[r] = 1'b0;
               beat[r] = 0;
               gap[r] = $urandom_range(max_gap);
               if (!was_free && r == m_cur) begin
                  m_free = 1'b1;
                  m_ptr = (r + 1) % N;
               end
            end
         end else if (gap[r] > 0 && q_size[r].size() > 0) begin
            gap[r]--;
         end
      end
   endtask

   task automatic run_drain(input int bound);
      int n;
      n = 0;
      while ((pending_any() || !m_free) && n < bound) begin
         cycle();
         n++;
      end
      chk("drain_timeout", 64'(n < bound), 64'(1));
   endtask

   initial begin
      int n;
      req_addr = '0; req_size = '0; req_addr_valid = '0;
      req_data = '0; req_valid = '0; ddr_addr_ready = 1'b0; ddr_ready = 1'b0;
      #2;
      do_reset();

      // single 4-beat burst from requester 0
      push(0, 32'h1000, 3);
      run_drain(50);
      chk("single_addr_hs", 64'(n_addr_hs), 64'(1));
      chk("single_beats", 64'(n_data_hs), 64'(4));
      chk("single_grant", 64'(hist.size() > 0 ? hist[0] : -1), 64'(0));
      chk("single_busy_end", 64'(busy), 64'(0));

      // contention with single-beat bursts
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push(0, AW'(32'h2000 + i * 16), 0);
         push(1, AW'(32'h8000 + i * 16), 0);
      end
      run_drain(100);
      chk("contention_hist_len", 64'(hist.size()), 64'(8));
      for (int i = 0; i < 4 && i < hist.size(); i++)
         chk("contention_grant", 64'(hist[i]), 64'(i % 2));
      chk("contention_beats", 64'(n_data_hs), 64'(8));

      // stalled 8-beat burst while requester 1 offers early data
      do_reset();
      stall_pat = 1'b1; p_early = 100;
      push(0, 32'h3000, 7);
      push(1, 32'h9000, 0);
      run_drain(200);
      chk("stall_beats", 64'(n_data_hs), 64'(9));
      chk("stall_order", 64'({hist.size() == 2, hist.size() > 1 ? hist[1] : -1}), 64'({1'b1, 32'd1}));

      // maximum burst, then the other requester
      do_reset();
      push(0, 32'h4000, (1 << BW) - 1);
      push(1, 32'hA000, 0);
      push(0, 32'h4100, 0);
      run_drain(200);
      chk("max_beats", 64'(n_data_hs), 64'((1 << BW) + 2));
      chk("max_next_grant", 64'(hist.size() > 1 ? hist[1] : -1), 64'(1));

      // reset after two of four beats
      do_reset();
      push(0, 32'h5000, 3);
      n = 0;
      while (n_data_hs < 2 && n < 30) begin
         cycle();
         n++;
      end
      chk("mid_rst_reached", 64'(n_data_hs), 64'(2));
      do_reset();
      push(1, 32'hB000, 0);
      push(0, 32'h5100, 0);
      run_drain(50);
      chk("post_rst_first_grant", 64'(hist.size() > 0 ? hist[0] : -1), 64'(0));

      // randomized traffic
      do_reset();
      p_ardy = 70; p_rdy = 75; p_val = 80; p_early = 30; max_gap = 3;
      for (int i = 0; i < 40; i++)
         for (int r = 0; r < N; r++)
            push(r, AW'($urandom), $urandom_range((1 << BW) - 1));
      run_drain(20000);
      chk("random_beats", 64'(n_data_hs), 64'(exp_beats));
      chk("random_bursts", 64'(n_addr_hs), 64'(80));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
